// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared encodings and types for the decode step controller
package decode_pkg;

    localparam logic [5:0] OPC_INVALID = 6'h3F;

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_REG  = 2'd1;
    localparam logic [1:0] KIND_MEM  = 2'd2;

    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
    } hint_t;

    typedef enum logic [1:0] {
        FC_NONE         = 2'd0,
        FC_BAD_OPC      = 2'd1,
        FC_BAD_HINT_CNT = 2'd2,
        FC_NO_WR_HINT   = 2'd3
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

endpackage

// File: rtl/decode_step_check.sv
// rtl/decode_step_check.sv - prioritised fault classification of one decoded step
module decode_step_check
    import decode_pkg::*;
(
    input  logic [1:0] hint_cnt_i,
    input  logic       wr_hint_i,
    input  logic [5:0] opc_i,
    input  logic [1:0] dest0_kind_i,
    input  logic [1:0] dest1_kind_i,
    output logic [1:0] fault_code_o
);

    fault_code_e code;

    // A malformed hint count masks everything else; a bad opcode masks the hint check.
    always_comb begin
        code = FC_NONE;
        if (hint_cnt_i == 2'd3) begin
            code = FC_BAD_HINT_CNT;
        end else if (opc_i == OPC_INVALID) begin
            code = FC_BAD_OPC;
        end else if (((dest0_kind_i == KIND_MEM) || (dest1_kind_i == KIND_MEM)) && !wr_hint_i) begin
            code = FC_NO_WR_HINT;
        end
    end

    assign fault_code_o = code;

endmodule

// File: rtl/decode_step_ctrl.sv
// rtl/decode_step_ctrl.sv - sequences trace steps through the external decode block
module decode_step_ctrl
    import decode_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [95:0]      step_raw_instr,
    input  logic [255:0]     step_regs,
    input  logic [1:0]       step_hint_cnt,
    input  logic [64:0]      step_hint1,
    input  logic [64:0]      step_hint2,
    output logic [95:0]      dec_raw_instr,
    output logic [255:0]     dec_regs,
    output logic [64:0]      dec_hint1,
    output logic [64:0]      dec_hint2,
    input  logic [5:0]       dec_opc,
    input  logic [95:0]      dec_opnd,
    input  logic [67:0]      dec_dest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_opc,
    output logic [95:0]      out_opnd,
    output logic [67:0]      out_dest,
    output logic [CNT_W-1:0] step_count,
    output logic             fault,
    output logic [1:0]       fault_code
);

    state_e            state_q, state_d;
    logic [95:0]       dec_raw_q;
    logic [255:0]      dec_regs_q;
    hint_t             dec_hint1_q, dec_hint2_q;
    hint_t             hint1_in, hint2_in;
    logic [1:0]        hint_cnt_q;
    logic              wr_hint_q;
    logic              out_valid_q;
    logic [5:0]        out_opc_q;
    logic [95:0]       out_opnd_q;
    logic [67:0]       out_dest_q;
    logic [CNT_W-1:0]  step_count_q;
    logic              fault_q;
    fault_code_e       fault_code_q;

    logic              rdy, accept, capture, out_fire, fault_set;
    logic              hint1_vld, hint2_vld, wr_hint_in;
    logic [1:0]        chk_code;

    assign hint1_in   = step_hint1;
    assign hint2_in   = step_hint2;
    assign hint1_vld  = (step_hint_cnt != 2'd0);
    assign hint2_vld  = step_hint_cnt[1];
    assign wr_hint_in = (hint1_vld && hint1_in.is_write) || (hint2_vld && hint2_in.is_write);

    decode_step_check u_check (
        .hint_cnt_i   (hint_cnt_q),
        .wr_hint_i    (wr_hint_q),
        .opc_i        (dec_opc),
        .dest0_kind_i (dec_dest[65:64]),
        .dest1_kind_i (dec_dest[67:66]),
        .fault_code_o (chk_code)
    );

    always_comb begin
        state_d   = state_q;
        rdy       = 1'b0;
        capture   = 1'b0;
        out_fire  = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (step_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (chk_code != FC_NONE) begin
                    fault_set = 1'b1;
                    state_d   = ST_FAULT;
                end else begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_fire = 1'b1;
                    rdy      = 1'b1;
                    state_d  = step_valid ? ST_DECODE : ST_IDLE;
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    assign accept = step_valid && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dec_raw_q    <= '0;
            dec_regs_q   <= '0;
            dec_hint1_q  <= '0;
            dec_hint2_q  <= '0;
            hint_cnt_q   <= '0;
            wr_hint_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_opc_q    <= '0;
            out_opnd_q   <= '0;
            out_dest_q   <= '0;
            step_count_q <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dec_raw_q   <= step_raw_instr;
                dec_regs_q  <= step_regs;
                dec_hint1_q <= hint1_vld ? hint1_in : '0;
                dec_hint2_q <= hint2_vld ? hint2_in : '0;
                hint_cnt_q  <= step_hint_cnt;
                wr_hint_q   <= wr_hint_in;
            end
            if (capture) begin
                out_valid_q <= 1'b1;
                out_opc_q   <= dec_opc;
                out_opnd_q  <= dec_opnd;
                out_dest_q  <= dec_dest;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            if (out_fire) step_count_q <= step_count_q + CNT_W'(1);
            if (fault_set) begin
                fault_q      <= 1'b1;
                fault_code_q <= fault_code_e'(chk_code);
            end
        end
    end

    // Held low during reset so nothing is accepted until the controller is live.
    assign step_ready    = rdy && !rst;
    assign dec_raw_instr = dec_raw_q;
    assign dec_regs      = dec_regs_q;
    assign dec_hint1     = dec_hint1_q;
    assign dec_hint2     = dec_hint2_q;
    assign out_valid     = out_valid_q;
    assign out_opc       = out_opc_q;
    assign out_opnd      = out_opnd_q;
    assign out_dest      = out_dest_q;
    assign step_count    = step_count_q;
    assign fault         = fault_q;
    assign fault_code    = fault_code_q;

endmodule

// File: tb/tb_decode_step_ctrl.sv
// tb/tb_decode_step_ctrl.sv - randomized scoreboard bench for decode_step_ctrl
module tb_decode_step_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         step_valid;
    logic         step_ready;
    logic [95:0]  step_raw_instr;
    logic [255:0] step_regs;
    logic [1:0]   step_hint_cnt;
    logic [64:0]  step_hint1, step_hint2;
    logic [95:0]  dec_raw_instr;
    logic [255:0] dec_regs;
    logic [64:0]  dec_hint1, dec_hint2;
    logic [5:0]   dec_opc;
    logic [95:0]  dec_opnd;
    logic [67:0]  dec_dest;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [5:0]   out_opc;
    logic [95:0]  out_opnd;
    logic [67:0]  out_dest;
    logic [31:0]  step_count;
    logic         fault;
    logic [1:0]   fault_code;

    decode_step_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .step_valid(step_valid), .step_ready(step_ready),
        .step_raw_instr(step_raw_instr), .step_regs(step_regs),
        .step_hint_cnt(step_hint_cnt), .step_hint1(step_hint1), .step_hint2(step_hint2),
        .dec_raw_instr(dec_raw_instr), .dec_regs(dec_regs),
        .dec_hint1(dec_hint1), .dec_hint2(dec_hint2),
        .dec_opc(dec_opc), .dec_opnd(dec_opnd), .dec_dest(dec_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opc(out_opc), .out_opnd(out_opnd), .out_dest(out_dest),
        .step_count(step_count), .fault(fault), .fault_code(fault_code)
    );

    // Stand-in for the combinational decode block: a simple function of its inputs.
    assign dec_opc  = dec_raw_instr[5:0];
    assign dec_opnd = dec_raw_instr ^ dec_regs[95:0];
    assign dec_dest = {dec_raw_instr[95:92], dec_regs[255:192]};

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  opc;
        logic [95:0] opnd;
        logic [67:0] dest;
        logic [64:0] h1;
        logic [64:0] h2;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic [31:0] exp_cnt = '0;

    logic [95:0]  s_raw;
    logic [255:0] s_regs;
    logic [1:0]   s_cnt;
    logic [64:0]  s_h1, s_h2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_code(input logic [95:0] raw, input logic [1:0] cnt,
                                              input logic [64:0] h1, input logic [64:0] h2);
        logic wr;
        logic mem;
        wr  = (cnt >= 2'd1 && h1[64]) || (cnt >= 2'd2 && h2[64]);
        mem = (raw[93:92] == 2'd2) || (raw[95:94] == 2'd2);
        if (cnt == 2'd3) return 2'd2;
        if (raw[5:0] == 6'h3F) return 2'd1;
        if (mem && !wr) return 2'd3;
        return 2'd0;
    endfunction

    task automatic gen_ok();
        logic wr;
        s_raw  = {$urandom, $urandom, $urandom};
        s_regs = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s_cnt  = 2'($urandom_range(0, 2));
        s_h1   = {1'($urandom_range(0, 1)), $urandom, $urandom};
        s_h2   = {1'($urandom_range(0, 1)), $urandom, $urandom};
        if (s_raw[5:0] == 6'h3F) s_raw[5:0] = 6'h00;
        wr = (s_cnt >= 2'd1 && s_h1[64]) || (s_cnt >= 2'd2 && s_h2[64]);
        if (!wr) begin
            if (s_raw[93:92] == 2'd2) s_raw[93:92] = 2'd1;
            if (s_raw[95:94] == 2'd2) s_raw[95:94] = 2'd1;
        end
    endtask

    // Offers the s_* step; returns just after the accepting edge with step_valid dropped.
    task automatic send(output int acc);
        bit   ok;
        exp_t e;
        step_raw_instr = s_raw;
        step_regs      = s_regs;
        step_hint_cnt  = s_cnt;
        step_hint1     = s_h1;
        step_hint2     = s_h2;
        step_valid     = 1'b1;
        ok  = 0;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (step_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout: got no step_ready expected step_ready=1");
            step_valid = 1'b0;
            return;
        end
        if (model_code(s_raw, s_cnt, s_h1, s_h2) == 2'd0) begin
            e.opc  = s_raw[5:0];
            e.opnd = s_raw ^ s_regs[95:0];
            e.dest = {s_raw[95:92], s_regs[255:192]};
            e.h1   = (s_cnt >= 2'd1) ? s_h1 : 65'd0;
            e.h2   = (s_cnt >= 2'd2) ? s_h2 : 65'd0;
            sb.push_back(e);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        step_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_step_ready", step_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_code", fault_code, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_dec_raw", dec_raw_instr, 0);
        chk("rst_out_opc", out_opc, 0);
        sb.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_step_ready", step_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic fault_run(input logic [1:0] exp_code);
        int          acc;
        logic [31:0] cnt_before;
        cnt_before = step_count;
        send(acc);
        @(negedge clk);
        @(negedge clk);
        chk("fault_flag", fault, 1);
        chk("fault_code", fault_code, exp_code);
        step_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fault_step_ready", step_ready, 0);
            chk("fault_out_valid", out_valid, 0);
            chk("fault_count_frozen", step_count, cnt_before);
        end
        step_valid = 1'b0;
    endtask

    // Monitor: scoreboard pops on every out handshake; also checks HOLD stability.
    initial begin
        exp_t        e;
        logic        prev_hold;
        logic [5:0]  h_opc;
        logic [95:0] h_opnd;
        logic [67:0] h_dest;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && out_valid) begin
                    chk("hold_opc", out_opc, h_opc);
                    chk("hold_opnd", out_opnd, h_opnd);
                    chk("hold_dest", out_dest, h_dest);
                end
                if (out_valid) chk("hold_step_ready", step_ready, out_ready);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_out: got out_valid expected no pending step");
                    end else begin
                        e = sb.pop_front();
                        chk("out_opc", out_opc, e.opc);
                        chk("out_opnd", out_opnd, e.opnd);
                        chk("out_dest", out_dest, e.dest);
                        chk("dec_hint1", dec_hint1, e.h1);
                        chk("dec_hint2", dec_hint2, e.h2);
                        chk("count_at_fire", step_count, exp_cnt);
                        exp_cnt = exp_cnt + 32'd1;
                    end
                end
                prev_hold = out_valid && !out_ready;
                h_opc  = out_opc;
                h_opnd = out_opnd;
                h_dest = out_dest;
            end
        end
    end

    initial begin
        int acc;
        int accs[5];
        rst            = 1'b1;
        step_valid     = 1'b0;
        step_raw_instr = '0;
        step_regs      = '0;
        step_hint_cnt  = '0;
        step_hint1     = '0;
        step_hint2     = '0;
        do_reset();

        // first step: latency and count
        gen_ok();
        s_cnt = 2'd0;
        s_raw[95:92] = 4'b0101;
        send(acc);
        @(negedge clk);
        chk("lat_decode_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_hold_out_valid", out_valid, 1);
        @(negedge clk);
        chk("first_count", step_count, 1);

        // back-to-back
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            gen_ok();
            send(accs[k]);
        end
        for (int k = 1; k < 5; k++) chk("b2b_spacing", 32'(accs[k] - accs[k-1]), 2);
        drain();
        chk("b2b_count", step_count, 6);

        // stall in HOLD for 4 cycles
        ready_mode = 2;
        @(posedge clk);
        #2;
        gen_ok();
        send(acc);
        repeat (5) @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_count", step_count, 6);
        ready_mode = 0;
        drain();
        chk("stall_release_count", step_count, 7);

        // randomized traffic with random backpressure and gaps
        ready_mode = 1;
        @(posedge clk);
        #2;
        for (int k = 0; k < 40; k++) begin
            gen_ok();
            send(acc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 0;
        drain();
        chk("rand_count", step_count, 47);

        // counter wrap
        @(posedge clk);
        #2;
        force dut.step_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.step_count_q;
        exp_cnt = 32'hFFFF_FFFF;
        gen_ok();
        send(acc);
        drain();
        chk("wrap_count", step_count, 0);

        // reset while in DECODE discards the step
        @(posedge clk);
        #2;
        gen_ok();
        send(acc);
        do_reset();
        gen_ok();
        send(acc);
        drain();
        chk("post_rst_count", step_count, 1);

        // invalid opcode after one good step
        @(posedge clk);
        #2;
        gen_ok();
        s_raw[5:0] = 6'h3F;
        fault_run(2'd1);

        // memory destination without a write hint
        do_reset();
        gen_ok();
        s_raw[93:92] = 2'd2;
        s_cnt = 2'd1;
        s_h1[64] = 1'b0;
        fault_run(2'd3);

        // same step with malformed hint count takes priority
        do_reset();
        gen_ok();
        s_raw[93:92] = 2'd2;
        s_cnt = 2'd3;
        s_h1[64] = 1'b0;
        s_h2[64] = 1'b0;
        fault_run(2'd2);

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
